// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   // Fetch controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   // Instruction width in bytes; PC step per fetch
   localparam int unsigned INSTR_BYTES = 32'd4;

   // Canonical bubble instruction: addi x0,x0,0
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

   // Contents of the IF/ID pipeline register
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } if_id_t;

   // A fetch PC is legal when word aligned and the whole word lies inside memory
   function automatic logic pc_is_legal(input logic [31:0] pc,
                                        input logic [31:0] imem_bytes);
      logic [31:0] last_word_s;
      last_word_s = imem_bytes - 32'(INSTR_BYTES);
      return (pc[1:0] == 2'b00) && (pc <= last_word_s);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load on accepted fetch, flush to a bubble,
// otherwise hold (stall). Flush wins over load.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   load_en,
   input  logic   flush,
   input  if_id_t d,
   output if_id_t q
);

   if_id_t q_r;

   // Pipeline register with bubble insertion; pc fields hold across a flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_r.valid    <= 1'b0;
         q_r.pc       <= 32'h0000_0000;
         q_r.pc_plus4 <= 32'h0000_0000;
         q_r.instr    <= NOP_INSTR;
      end else if (flush) begin
         q_r.valid    <= 1'b0;
         q_r.instr    <= NOP_INSTR;
      end else if (load_en) begin
         q_r          <= d;
      end else begin
         q_r          <= q_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory,
// registers the returned word into IF/ID, and handles stall, redirect with
// flush, and sticky alignment/range faults.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 32'd1024,
   parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] addr_insmem,
   input  logic [31:0] instruction,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic [31:0] if_instr,
   output logic        fetch_fault,
   output logic [31:0] fault_pc,
   output logic [31:0] fetch_count
);

   fetch_state_e state_r;
   fetch_state_e state_next_s;
   logic [31:0]  pc_r;
   logic [31:0]  pc_next_s;
   logic [31:0]  pc_plus4_s;
   logic         pc_legal_s;
   logic         load_s;
   logic         flush_s;
   logic         fault_set_s;
   logic         fetch_fault_r;
   logic [31:0]  fault_pc_r;
   logic [31:0]  fetch_count_r;
   if_id_t       if_id_d_s;
   if_id_t       if_id_q_s;

   assign pc_plus4_s = pc_r + 32'(INSTR_BYTES);
   assign pc_legal_s = pc_is_legal(pc_r, 32'(IMEM_BYTES));

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next state: redirect beats stall and fault; start only matters in IDLE
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (!redirect_valid && id_ready && !pc_legal_s) begin
               state_next_s = FAULT;
            end else begin
               state_next_s = RUN;
            end
         end
         FAULT: begin
            if (redirect_valid) begin
               state_next_s = RUN;
            end else begin
               state_next_s = FAULT;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // FSM outputs: PC update and IF/ID load/flush/fault controls
   always_comb begin
      load_s      = 1'b0;
      flush_s     = 1'b0;
      fault_set_s = 1'b0;
      pc_next_s   = pc_r;
      case (state_r)
         IDLE, FAULT: begin
            if (redirect_valid) begin
               pc_next_s = redirect_pc;
            end else begin
               pc_next_s = pc_r;
            end
         end
         RUN: begin
            if (redirect_valid) begin
               pc_next_s = redirect_pc;
               flush_s   = 1'b1;
            end else if (id_ready) begin
               if (pc_legal_s) begin
                  load_s    = 1'b1;
                  pc_next_s = pc_plus4_s;
               end else begin
                  fault_set_s = 1'b1;
                  flush_s     = 1'b1;
               end
            end else begin
               pc_next_s = pc_r;
            end
         end
         default: begin
            pc_next_s = RESET_PC;
         end
      endcase
   end

   // Program counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= pc_next_s;
      end
   end

   // Sticky fault flag with the offending PC captured once per fault event
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_fault_r <= 1'b0;
         fault_pc_r    <= 32'h0000_0000;
      end else if (fault_set_s) begin
         fetch_fault_r <= 1'b1;
         fault_pc_r    <= pc_r;
      end else begin
         fetch_fault_r <= fetch_fault_r;
         fault_pc_r    <= fault_pc_r;
      end
   end

   // Count of instructions handed to decode; wraps naturally at 2^32
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count_r <= 32'h0000_0000;
      end else if (load_s) begin
         fetch_count_r <= fetch_count_r + 32'd1;
      end else begin
         fetch_count_r <= fetch_count_r;
      end
   end

   assign if_id_d_s.valid    = 1'b1;
   assign if_id_d_s.pc       = pc_r;
   assign if_id_d_s.pc_plus4 = pc_plus4_s;
   assign if_id_d_s.instr    = instruction;

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk     (clk),
      .rst     (rst),
      .load_en (load_s),
      .flush   (flush_s),
      .d       (if_id_d_s),
      .q       (if_id_q_s)
   );

   assign addr_insmem = pc_r;
   assign if_valid    = if_id_q_s.valid;
   assign if_pc       = if_id_q_s.pc;
   assign if_pc_plus4 = if_id_q_s.pc_plus4;
   assign if_instr    = if_id_q_s.instr;
   assign fetch_fault = fetch_fault_r;
   assign fault_pc    = fault_pc_r;
   assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run compared against a behavioural model of the fetch rules.
module tb_instruction_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int unsigned IMEM = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        id_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] addr_insmem;
   logic [31:0] instruction;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic [31:0] if_instr;
   logic        fetch_fault;
   logic [31:0] fault_pc;
   logic [31:0] fetch_count;

   logic [31:0] words [0:255];
   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model: 0 = idle, 1 = running, 2 = faulted
   int          m_mode;
   logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_fpc, m_cnt;
   logic        m_valid, m_fault;

   instruction_fetch #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_BYTES (1024),
      .NOP_INSTR  (32'h0000_0013)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .addr_insmem    (addr_insmem),
      .instruction    (instruction),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4),
      .if_instr       (if_instr),
      .fetch_fault    (fetch_fault),
      .fault_pc       (fault_pc),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   // combinational instruction memory
   always_comb begin
      if (addr_insmem < 32'(IMEM) && addr_insmem[1:0] == 2'b00)
         instruction = words[addr_insmem[9:2]];
      else
         instruction = 32'hDEAD_BEEF;
   end

   task automatic model_reset();
      m_mode = 0; m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
      m_instr = NOP; m_fpc = 32'h0; m_cnt = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
   endtask

   task automatic model_step(input logic s, input logic rdy, input logic rv, input logic [31:0] rpc);
      bit legal;
      legal = (m_pc % 4 == 0) && (m_pc <= 32'(IMEM - 4));
      if (m_mode == 0) begin
         if (rv) m_pc = rpc;
         if (s) m_mode = 1;
      end else if (m_mode == 1) begin
         if (rv) begin
            m_pc = rpc; m_valid = 1'b0; m_instr = NOP;
         end else if (rdy && legal) begin
            m_instr = words[m_pc / 4]; m_ifpc = m_pc; m_ifpc4 = m_pc + 4;
            m_valid = 1'b1; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
         end else if (rdy) begin
            m_fault = 1'b1; m_fpc = m_pc; m_valid = 1'b0; m_instr = NOP; m_mode = 2;
         end
      end else begin
         if (rv) begin m_pc = rpc; m_mode = 1; end
      end
   endtask

   task automatic tick(input logic s, input logic rdy, input logic rv, input logic [31:0] rpc);
      start = s; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
      @(posedge clk);
      model_step(s, rdy, rv, rpc);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      model_reset();
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
      model_reset();
      #1;
      n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
      n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
      n_cmp++; if (if_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL reset_pc4 got=%h exp=0", if_pc_plus4); end
      n_cmp++; if (if_instr !== NOP) begin n_bad++; $display("FAIL reset_instr got=%h exp=%h", if_instr, NOP); end
      n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
      n_cmp++; if (fault_pc !== 32'h0) begin n_bad++; $display("FAIL reset_fault_pc got=%h exp=0", fault_pc); end
      n_cmp++; if (fetch_count !== 32'h0) begin n_bad++; $display("FAIL reset_count got=%h exp=0", fetch_count); end
      n_cmp++; if (addr_insmem !== 32'h0) begin n_bad++; $display("FAIL reset_addr got=%h exp=0", addr_insmem); end
      #2; rst = 1'b0;
      // redirect in IDLE overrides the boot vector without starting
      tick(1'b0, 1'b1, 1'b1, 32'h20);
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (addr_insmem !== 32'h20) begin n_bad++; $display("FAIL idle_redirect_addr got=%h exp=20", addr_insmem); end
      n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL idle_no_fetch got=%b exp=0", if_valid); end
   endtask

   task automatic test_sequential();
      do_reset();
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL seq_start_cycle_valid got=%b exp=0", if_valid); end
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b1, 1'b0, 32'h0);
         n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL seq_valid i=%0d got=%b exp=1", i, if_valid); end
         n_cmp++; if (if_pc !== 32'(4 * i)) begin n_bad++; $display("FAIL seq_pc i=%0d got=%h exp=%h", i, if_pc, 4 * i); end
         n_cmp++; if (if_instr !== words[i]) begin n_bad++; $display("FAIL seq_instr i=%0d got=%h exp=%h", i, if_instr, words[i]); end
      end
      n_cmp++; if (fetch_count !== 32'd4) begin n_bad++; $display("FAIL seq_count got=%0d exp=4", fetch_count); end
      n_cmp++; if (if_pc_plus4 !== 32'd16) begin n_bad++; $display("FAIL seq_pc4 got=%h exp=10", if_pc_plus4); end
   endtask

   task automatic test_stall();
      do_reset();
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 1'b0, 32'h0);
         n_cmp++; if (if_pc !== 32'd8 || if_instr !== words[2] || addr_insmem !== 32'd12 || if_valid !== 1'b1)
            begin n_bad++; $display("FAIL stall_hold i=%0d got=%h/%h/%h exp=8/%h/c", i, if_pc, if_instr, addr_insmem, words[2]); end
      end
      n_cmp++; if (fetch_count !== 32'd3) begin n_bad++; $display("FAIL stall_count got=%0d exp=3", fetch_count); end
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (if_pc !== 32'd12) begin n_bad++; $display("FAIL stall_release got=%h exp=c", if_pc); end
   endtask

   task automatic test_redirect_and_fault();
      do_reset();
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 1'b1, 32'h40);
      n_cmp++; if (if_valid !== 1'b0 || if_instr !== NOP) begin n_bad++; $display("FAIL redir_bubble got=%b/%h exp=0/%h", if_valid, if_instr, NOP); end
      n_cmp++; if (if_pc !== 32'd4 || fetch_count !== 32'd2) begin n_bad++; $display("FAIL redir_hold got=%h/%0d exp=4/2", if_pc, fetch_count); end
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (if_pc !== 32'h40 || if_instr !== words[16] || fetch_count !== 32'd3)
         begin n_bad++; $display("FAIL redir_target got=%h/%h/%0d exp=40/%h/3", if_pc, if_instr, fetch_count, words[16]); end
      // misaligned redirect target faults on the following cycle
      tick(1'b0, 1'b1, 1'b1, 32'h42);
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (fetch_fault !== 1'b1 || fault_pc !== 32'h42 || if_valid !== 1'b0)
         begin n_bad++; $display("FAIL fault_set got=%b/%h/%b exp=1/42/0", fetch_fault, fault_pc, if_valid); end
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (if_valid !== 1'b0 || addr_insmem !== 32'h42 || fetch_count !== 32'd3)
         begin n_bad++; $display("FAIL fault_hold got=%b/%h/%0d exp=0/42/3", if_valid, addr_insmem, fetch_count); end
      tick(1'b0, 1'b1, 1'b1, 32'h80);
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_instr !== words[32] || fetch_fault !== 1'b1)
         begin n_bad++; $display("FAIL fault_recover got=%b/%h/%h/%b exp=1/80/%h/1", if_valid, if_pc, if_instr, fetch_fault, words[32]); end
   endtask

   task automatic test_range_end();
      do_reset();
      tick(1'b1, 1'b1, 1'b1, 32'h3F0);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b1, 1'b0, 32'h0);
         n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h3F0 + 32'(4 * i) || if_instr !== words[252 + i])
            begin n_bad++; $display("FAIL range_fetch i=%0d got=%b/%h/%h", i, if_valid, if_pc, if_instr); end
      end
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (fetch_fault !== 1'b1 || fault_pc !== 32'h400 || if_valid !== 1'b0 || fetch_count !== 32'd4)
         begin n_bad++; $display("FAIL range_fault got=%b/%h/%b/%0d exp=1/400/0/4", fetch_fault, fault_pc, if_valid, fetch_count); end
   endtask

   task automatic test_async_reset();
      do_reset();
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);
      #3;
      redirect_valid = 1'b1; redirect_pc = 32'h100; id_ready = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      n_cmp++; if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0)
         begin n_bad++; $display("FAIL areset_ifid got=%b/%h/%h/%h", if_valid, if_instr, if_pc, if_pc_plus4); end
      n_cmp++; if (fetch_count !== 32'h0 || addr_insmem !== 32'h0 || fetch_fault !== 1'b0)
         begin n_bad++; $display("FAIL areset_state got=%0d/%h/%b exp=0/0/0", fetch_count, addr_insmem, fetch_fault); end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (if_valid !== 1'b0 || addr_insmem !== 32'h0 || fetch_count !== 32'h0)
         begin n_bad++; $display("FAIL areset_idle got=%b/%h/%0d exp=0/0/0", if_valid, addr_insmem, fetch_count); end
   endtask

   task automatic test_random();
      logic s, rdy, rv;
      logic [31:0] rpc;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         s   = ($urandom_range(0, 19) == 0) || (c == 0);
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 9))
            0:       rpc = 32'($urandom_range(0, 1023)) | 32'd1;
            1:       rpc = 32'h400 + (32'($urandom_range(0, 15)) << 2);
            default: rpc = 32'($urandom_range(0, 255)) << 2;
         endcase
         tick(s, rdy, rv, rpc);
         n_cmp++; if (addr_insmem !== m_pc) begin n_bad++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, addr_insmem, m_pc); end
         n_cmp++; if (if_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, if_valid, m_valid); end
         n_cmp++; if (if_pc !== m_ifpc) begin n_bad++; $display("FAIL rnd_ifpc c=%0d got=%h exp=%h", c, if_pc, m_ifpc); end
         n_cmp++; if (if_pc_plus4 !== m_ifpc4) begin n_bad++; $display("FAIL rnd_pc4 c=%0d got=%h exp=%h", c, if_pc_plus4, m_ifpc4); end
         n_cmp++; if (if_instr !== m_instr) begin n_bad++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, if_instr, m_instr); end
         n_cmp++; if (fetch_fault !== m_fault) begin n_bad++; $display("FAIL rnd_fault c=%0d got=%b exp=%b", c, fetch_fault, m_fault); end
         n_cmp++; if (fault_pc !== m_fpc) begin n_bad++; $display("FAIL rnd_fault_pc c=%0d got=%h exp=%h", c, fault_pc, m_fpc); end
         n_cmp++; if (fetch_count !== m_cnt) begin n_bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, fetch_count, m_cnt); end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) words[i] = $urandom;
      model_reset();
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_and_fault();
      test_range_end();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of instruction_memory. It owns the program counter and drives the byte address into the combinational instruction memory, which returns {mem[a],mem[a+1],mem[a+2],mem[a+3]}. It registers the returned word into an IF/ID pipeline register for decode. It handles stall, branch/jump redirect with flush, and alignment/range faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_BYTES, 1024, instruction memory size in bytes; legal fetch PCs are 0..IMEM_BYTES-4.
NOP_INSTR, 32'h0000_0013, value placed in if_instr on flush, reset or bubble (addi x0,x0,0).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  level; leave IDLE and begin fetching
id_ready  input  1  decode accepts IF/ID this cycle; 0 = stall
redirect_valid  input  1  taken branch/jal/jalr from execute
redirect_pc  input  32  redirect target byte address
addr_insmem  output  32  byte address to instruction_memory (= pc_q, combinational)
instruction  input  32  word returned by instruction_memory, same cycle
if_valid  output  1  IF/ID holds a real instruction
if_pc  output  32  PC of if_instr
if_pc_plus4  output  32  if_pc + 4, for jal/jalr link
if_instr  output  32  fetched instruction
fetch_fault  output  1  sticky; set on illegal fetch PC
fault_pc  output  32  PC that caused the fault
fetch_count  output  32  number of instructions emitted (if_valid loads)

Behaviour:
- Reset (async, any state): pc_q=RESET_PC; state=IDLE; if_valid=0; if_pc=0; if_pc_plus4=0; if_instr=NOP_INSTR; fetch_fault=0; fault_pc=0; fetch_count=0.
- addr_insmem = pc_q at all times. The memory is combinational, so fetch latency is 1 cycle from PC to IF/ID.
- "Advance" means state==RUN && id_ready && !redirect_valid && PC legal.
- PC legal means pc_q[1:0]==0 and pc_q <= IMEM_BYTES-4.
- States:
  - IDLE: PC is held and if_valid=0. On start=1, go to RUN at the next edge. No fetch occurs in the cycle start is sampled.
  - RUN:
    - On advance: if_instr<=instruction, if_pc<=pc_q, if_pc_plus4<=pc_q+4, if_valid<=1, pc_q<=pc_q+4, fetch_count+=1.
    - id_ready=0 (stall): pc_q and all IF/ID outputs hold.
    - redirect_valid=1 has highest priority, over stall and over fault detection: pc_q<=redirect_pc, if_valid<=0, if_instr<=NOP_INSTR, if_pc/if_pc_plus4 hold, fetch_count holds. Fetching resumes at the target the next cycle, giving a one-bubble penalty.
    - Illegal PC, no redirect, id_ready=1: fetch_fault<=1, fault_pc<=pc_q, if_valid<=0, if_instr<=NOP_INSTR, go to FAULT.
    - Illegal PC while stalled: no fault yet; the check fires when id_ready rises.
  - FAULT: pc_q holds, if_valid=0, and no fetches occur.
    - redirect_valid=1 loads redirect_pc and returns to RUN. fetch_fault stays set until reset.
    - start is ignored in FAULT.
- Arithmetic: PC arithmetic is 32-bit modulo 2^32 (0xFFFF_FFFC+4=0). This is unreachable in practice because of the range check. fetch_count wraps at 2^32.
- redirect_valid in IDLE: pc_q<=redirect_pc and the state stays IDLE, so the boot vector can be overridden.
- start deasserted in RUN has no effect; RUN is left only by fault or reset.
- A reset asserted mid-stall or mid-redirect clears everything immediately. No partial update survives.

Decomposition:
- Package fetch_pkg: fetch_state_e {IDLE, RUN, FAULT}; INSTR_BYTES=4; default NOP_INSTR; an if_id_t struct {valid, pc, pc_plus4, instr}.
- Sub-module if_id_reg: the IF/ID pipeline register. It has async reset, a load enable, and a flush that forces valid=0 and instr=NOP. PC/next-PC logic and the FSM stay in instruction_fetch.

Test Plan:
1. Reset then start=1, id_ready=1, memory preloaded with words W0..W3 at 0,4,8,12 -> if_valid rises 2 cycles after start is sampled; if_pc sequence 0,4,8,12 with if_instr W0..W3; fetch_count=4.
2. Stall: id_ready=0 for 3 cycles while if_pc=8 -> if_pc, if_instr and addr_insmem hold at 8/W2/12; on release the next if_pc=12.
3. Redirect to 0x40 while id_ready=0 at if_pc=4 -> next cycle if_valid=0 and if_instr=NOP; the following cycle if_pc=0x40 with mem[0x40..0x43]; fetch_count does not count the bubble.
4. Redirect to 0x42 -> one cycle later fetch_fault=1, fault_pc=0x42, if_valid=0 permanently. A redirect to 0x80 then resumes fetch at 0x80 while fetch_fault stays 1.
5. Sequential run to PC=IMEM_BYTES-4=0x3FC, then PC=0x400 -> 0x3FC is fetched normally; fault at fault_pc=0x400.
6. Assert rst asynchronously mid-run (between edges) with redirect_valid=1 -> all outputs reach their reset values immediately; pc_q=RESET_PC; state=IDLE; no fetch until start.
